// File: rtl/hack_exec_core.sv
// Hack execution core: A/D/PC registers, instruction decode, ALU control and
// jump resolution, with a RUN/WAIT FSM that stalls C-instructions reading M.

module alu16 (
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  logic        i_zx,
  input  logic        i_nx,
  input  logic        i_zy,
  input  logic        i_ny,
  input  logic        i_f,
  input  logic        i_no,
  output logic [15:0] o_out,
  output logic        o_zr,
  output logic        o_ng
);
  logic [15:0] w_x0;
  logic [15:0] w_x1;
  logic [15:0] w_y0;
  logic [15:0] w_y1;
  logic [15:0] w_f;

  assign w_x0  = i_zx ? 16'h0000 : i_x;
  assign w_x1  = i_nx ? ~w_x0 : w_x0;
  assign w_y0  = i_zy ? 16'h0000 : i_y;
  assign w_y1  = i_ny ? ~w_y0 : w_y0;
  assign w_f   = i_f ? (w_x1 + w_y1) : (w_x1 & w_y1);
  assign o_out = i_no ? ~w_f : w_f;
  assign o_zr  = (o_out == 16'h0000);
  assign o_ng  = o_out[15];
endmodule

module hack_exec_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [15:0] pc,
  output logic [14:0] mem_addr,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  output logic [15:0] a_out,
  output logic [15:0] d_out
);
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_a;
  logic [15:0] r_d;
  logic [15:0] r_pc;
  logic [12:0] r_ir;

  logic        w_run;
  logic        w_accept;
  logic        w_use_ir;
  logic [12:0] w_op;
  logic [15:0] w_y;
  logic [15:0] w_alu_out;
  logic        w_zr;
  logic        w_ng;
  logic        w_jmp;
  logic        w_a_instr;
  logic        w_exec_now;
  logic        w_exec_wait;
  logic        w_complete_c;
  logic        w_start_rd;
  logic [15:0] w_pc_inc;
  logic        w_unused_ok;

  // Handshake: an instruction transfers on a cycle where instr_valid and
  // instr_ready are both high; ready is high exactly while the FSM is in RUN.
  assign w_run       = (r_state == ST_RUN);
  assign instr_ready = w_run;
  assign w_accept    = rst_n & instr_valid & w_run;

  // The ALU sees the latched ir whenever no live instruction is being taken,
  // so reset and idle cycles show the ir=0 result on mem_wdata.
  assign w_use_ir = ~rst_n | ~w_run | ~instr_valid;
  assign w_op     = w_use_ir ? r_ir : instr[12:0];
  assign w_y      = w_op[12] ? mem_rdata : r_a;

  alu16 u_alu (
    .i_x  (r_d),
    .i_y  (w_y),
    .i_zx (w_op[11]),
    .i_nx (w_op[10]),
    .i_zy (w_op[9]),
    .i_ny (w_op[8]),
    .i_f  (w_op[7]),
    .i_no (w_op[6]),
    .o_out(w_alu_out),
    .o_zr (w_zr),
    .o_ng (w_ng)
  );

  assign w_jmp = (w_op[2] & w_ng) | (w_op[1] & w_zr) | (w_op[0] & ~w_ng & ~w_zr);

  assign w_a_instr    = w_accept & ~instr[15];
  assign w_exec_now   = w_accept & instr[15] & ~instr[12];
  assign w_start_rd   = w_accept & instr[15] & instr[12];
  assign w_exec_wait  = rst_n & (r_state == ST_WAIT) & mem_rvalid;
  assign w_complete_c = w_exec_now | w_exec_wait;
  assign w_pc_inc     = r_pc + 16'd1;

  assign mem_addr  = r_a[14:0];
  assign mem_re    = w_start_rd;
  assign mem_we    = w_complete_c & w_op[3];
  assign mem_wdata = w_alu_out;
  assign pc        = r_pc;
  assign a_out     = r_a;
  assign d_out     = r_d;

  // Bits 14:13 of a C-instruction carry no meaning.
  assign w_unused_ok = ^instr[14:13];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (w_start_rd) w_state_nxt = ST_WAIT;
      ST_WAIT: if (mem_rvalid) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Jump target and write address both use A before this instruction's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= 16'h0000;
      r_d  <= 16'h0000;
      r_pc <= 16'h0000;
      r_ir <= 13'h0000;
    end else begin
      if (w_a_instr) begin
        r_a  <= {1'b0, instr[14:0]};
        r_pc <= w_pc_inc;
      end else if (w_complete_c) begin
        if (w_op[5]) r_a <= w_alu_out;
        if (w_op[4]) r_d <= w_alu_out;
        r_pc <= w_jmp ? r_a : w_pc_inc;
      end
      if (w_start_rd) r_ir <= instr[12:0];
    end
  end
endmodule
